// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl
//  Description : Button front-end for a bin_counter. Synchronises and
//                debounces the clear, load and run/stop push-buttons, then
//                turns each accepted press into a one-cycle command pulse
//                (syn_clr, load with captured switch data) or a toggle of
//                the count enable. Can optionally stop at terminal count.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int DB_N      = 19,
    parameter int W         = 16,
    parameter bit AUTO_STOP = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         btn_clr,
    input  logic         btn_load,
    input  logic         btn_run,
    input  logic [W-1:0] sw,
    input  logic         max_tick,
    output logic         syn_clr,
    output logic         load,
    output logic         en,
    output logic [W-1:0] d,
    output logic         running
);

    // Button lane indices shared by the synchroniser and debounce arrays.
    localparam int c_NUM_BTN  = 3;
    localparam int c_IDX_CLR  = 0;
    localparam int c_IDX_LOAD = 1;
    localparam int c_IDX_RUN  = 2;

    localparam logic [DB_N-1:0] c_TICK_ONE = {{(DB_N-1){1'b0}}, 1'b1};

    // Debounce states: W1_x count tick edges while the input looks high,
    // W0_x count tick edges while it looks low after an accepted press.
    typedef enum logic [2:0] {
        ST_ZERO = 3'd0,
        ST_W1_1 = 3'd1,
        ST_W1_2 = 3'd2,
        ST_W1_3 = 3'd3,
        ST_ONE  = 3'd4,
        ST_W0_1 = 3'd5,
        ST_W0_2 = 3'd6,
        ST_W0_3 = 3'd7
    } db_state_t;

    logic [c_NUM_BTN-1:0] w_btn_raw;
    logic [c_NUM_BTN-1:0] r_sync_meta;
    logic [c_NUM_BTN-1:0] r_sync;
    logic [DB_N-1:0]      r_tick_cnt;
    logic                 w_tick;
    logic [c_NUM_BTN-1:0] w_press;

    logic                 r_syn_clr;
    logic                 r_load;
    logic                 r_en;
    logic [W-1:0]         r_d;

    logic                 w_clr_cmd;
    logic                 w_load_cmd;
    logic                 w_run_cmd;
    logic                 w_auto_stop;

    assign w_btn_raw[c_IDX_CLR]  = btn_clr;
    assign w_btn_raw[c_IDX_LOAD] = btn_load;
    assign w_btn_raw[c_IDX_RUN]  = btn_run;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_meta <= '0;
            r_sync      <= '0;
        end else begin
            r_sync_meta <= w_btn_raw;
            r_sync      <= r_sync_meta;
        end
    end

    // Free-running tick counter; the tick is the all-ones count, then it wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end
    end

    assign w_tick = &r_tick_cnt;

    // One debounce FSM and rising-edge detector per button.
    generate
        for (genvar gi = 0; gi < c_NUM_BTN; gi++) begin : g_db
            db_state_t r_state;
            logic      r_db;
            logic      r_db_q;
            logic      w_sync;

            assign w_sync = r_sync[gi];

            // Debounce FSM; r_db is the registered debounced level and is
            // only changed on the two transitions that cross ZERO/ONE.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_state <= ST_ZERO;
                    r_db    <= 1'b0;
                end else begin
                    case (r_state)
                        ST_ZERO: begin
                            if (w_sync) begin
                                r_state <= ST_W1_1;
                            end
                        end
                        ST_W1_1: begin
                            if (!w_sync) begin
                                r_state <= ST_ZERO;
                            end else if (w_tick) begin
                                r_state <= ST_W1_2;
                            end
                        end
                        ST_W1_2: begin
                            if (!w_sync) begin
                                r_state <= ST_ZERO;
                            end else if (w_tick) begin
                                r_state <= ST_W1_3;
                            end
                        end
                        ST_W1_3: begin
                            if (!w_sync) begin
                                r_state <= ST_ZERO;
                            end else if (w_tick) begin
                                r_state <= ST_ONE;
                                r_db    <= 1'b1;
                            end
                        end
                        ST_ONE: begin
                            if (!w_sync) begin
                                r_state <= ST_W0_1;
                            end
                        end
                        ST_W0_1: begin
                            if (w_sync) begin
                                r_state <= ST_ONE;
                            end else if (w_tick) begin
                                r_state <= ST_W0_2;
                            end
                        end
                        ST_W0_2: begin
                            if (w_sync) begin
                                r_state <= ST_ONE;
                            end else if (w_tick) begin
                                r_state <= ST_W0_3;
                            end
                        end
                        ST_W0_3: begin
                            if (w_sync) begin
                                r_state <= ST_ONE;
                            end else if (w_tick) begin
                                r_state <= ST_ZERO;
                                r_db    <= 1'b0;
                            end
                        end
                        default: begin
                            r_state <= ST_ZERO;
                            r_db    <= 1'b0;
                        end
                    endcase
                end
            end

            // Delayed copy of the debounced level for press detection.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_db_q <= 1'b0;
                end else begin
                    r_db_q <= r_db;
                end
            end

            // One-cycle pulse on each accepted press; release is ignored.
            assign w_press[gi] = r_db & ~r_db_q;
        end
    endgenerate

    // Clear wins over load; run toggling is independent of both.
    assign w_clr_cmd   = w_press[c_IDX_CLR];
    assign w_load_cmd  = w_press[c_IDX_LOAD] & ~w_press[c_IDX_CLR];
    assign w_run_cmd   = w_press[c_IDX_RUN];
    assign w_auto_stop = AUTO_STOP & r_en & max_tick;

    // Registered command outputs to the counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_syn_clr <= 1'b0;
            r_load    <= 1'b0;
            r_en      <= 1'b0;
            r_d       <= '0;
        end else begin
            r_syn_clr <= w_clr_cmd;
            r_load    <= w_load_cmd;
            if (w_load_cmd) begin
                r_d <= sw;
            end
            // Terminal-count stop overrides a coincident run toggle.
            if (w_auto_stop) begin
                r_en <= 1'b0;
            end else if (w_run_cmd) begin
                r_en <= ~r_en;
            end
        end
    end

    assign syn_clr = r_syn_clr;
    assign load    = r_load;
    assign en      = r_en;
    assign running = r_en;
    assign d       = r_d;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_ctrl
//  Description : Self-checking bench for counter_ctrl (DB_N=3). Runs one
//                auto-stop and one free-run instance side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int DB_N = 3;
    localparam int W    = 16;
    localparam int TMAX = (1 << DB_N) - 1;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         btn_clr, btn_load, btn_run;
    logic [W-1:0] sw;
    logic         max_tick;

    logic         a_syn_clr, a_load, a_en, a_running;
    logic [W-1:0] a_d;
    logic         b_syn_clr, b_load, b_en, b_running;
    logic [W-1:0] b_d;

    int n_cmp = 0;
    int n_bad = 0;
    int tot_clr = 0;
    int tot_ld  = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    counter_ctrl #(.DB_N(DB_N), .W(W), .AUTO_STOP(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .btn_clr(btn_clr), .btn_load(btn_load),
        .btn_run(btn_run), .sw(sw), .max_tick(max_tick), .syn_clr(a_syn_clr),
        .load(a_load), .en(a_en), .d(a_d), .running(a_running)
    );

    counter_ctrl #(.DB_N(DB_N), .W(W), .AUTO_STOP(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .btn_clr(btn_clr), .btn_load(btn_load),
        .btn_run(btn_run), .sw(sw), .max_tick(max_tick), .syn_clr(b_syn_clr),
        .load(b_load), .en(b_en), .d(b_d), .running(b_running)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Each button is debounced by counting tick edges
    // during which the synchronised input disagrees with the debounced
    // level; the third such tick flips the level, any agreement restarts.
    // ------------------------------------------------------------------
    bit          m_s1 [3];
    bit          m_s2 [3];
    bit          m_db [3];
    bit          m_dbq[3];
    int          m_arm[3];
    int          m_cnt;
    bit          m_syn_clr, m_load, m_en_a, m_en_b;
    logic [W-1:0] m_d;

    always @(posedge clk) begin : model
        bit tk;
        bit pr[3];
        bit raw[3];
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbq[i] = 0; m_arm[i] = -1;
            end
            m_cnt = 0; m_syn_clr = 0; m_load = 0; m_en_a = 0; m_en_b = 0; m_d = '0;
        end else begin
            raw[0] = btn_clr; raw[1] = btn_load; raw[2] = btn_run;
            tk = (m_cnt == TMAX);
            for (int i = 0; i < 3; i++) pr[i] = m_db[i] && !m_dbq[i];
            m_syn_clr = pr[0];
            m_load    = pr[1] && !pr[0];
            if (m_load) m_d = sw;
            if (m_en_a && max_tick) m_en_a = 0;
            else if (pr[2])         m_en_a = !m_en_a;
            if (pr[2])              m_en_b = !m_en_b;
            for (int i = 0; i < 3; i++) begin
                m_dbq[i] = m_db[i];
                if (m_s2[i] == m_db[i]) m_arm[i] = -1;
                else if (m_arm[i] < 0) m_arm[i] = 0;
                else if (tk) begin
                    m_arm[i]++;
                    if (m_arm[i] == 3) begin
                        m_db[i]  = !m_db[i];
                        m_arm[i] = -1;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = raw[i];
            end
            m_cnt = (m_cnt + 1) % (TMAX + 1);
        end
    end

    // Per-cycle comparison against the model, plus pulse tallies.
    always @(negedge clk) begin
        if (chk_on) begin
            if (!reset_n) begin
                check("reset_a", {a_syn_clr, a_load, a_en, a_running, a_d}, 64'd0);
                check("reset_b", {b_syn_clr, b_load, b_en, b_running, b_d}, 64'd0);
            end else begin
                check("cycle_a", {a_syn_clr, a_load, a_en, a_running, a_d},
                                 {m_syn_clr, m_load, m_en_a, m_en_a, m_d});
                check("cycle_b", {b_syn_clr, b_load, b_en, b_running, b_d},
                                 {m_syn_clr, m_load, m_en_b, m_en_b, m_d});
            end
            if (a_syn_clr) tot_clr++;
            if (a_load)    tot_ld++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic         clr;
        logic         ld;
        logic         run;
        int           hold;
        logic [W-1:0] sw_v;
        logic         mt;
        int           exp_clr;
        int           exp_ld;
        logic [W-1:0] exp_d;
        logic         exp_en_a;
        logic         exp_en_b;
    } vec_t;

    vec_t tbl[11];
    int   c0, l0, waited, rem[3];
    logic lvl[3];

    initial begin
        // clr ld  run hold sw        mt  #clr #ld d         en_a en_b
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 100, 16'h0000, 1'b0, 0, 0, 16'h0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0,  40, 16'hA5C3, 1'b0, 0, 1, 16'hA5C3, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0,  10, 16'h1234, 1'b0, 0, 0, 16'hA5C3, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0,  10, 16'h1234, 1'b0, 0, 0, 16'hA5C3, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0,  40, 16'h1234, 1'b0, 1, 0, 16'hA5C3, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0,  40, 16'hBEEF, 1'b0, 1, 0, 16'hA5C3, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1,  40, 16'hBEEF, 1'b0, 0, 0, 16'hA5C3, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0,   5, 16'hBEEF, 1'b1, 0, 0, 16'hA5C3, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1,  40, 16'hBEEF, 1'b0, 0, 0, 16'hA5C3, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0,  40, 16'h0F0F, 1'b0, 0, 1, 16'h0F0F, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0,   5, 16'h0F0F, 1'b1, 0, 0, 16'h0F0F, 1'b0, 1'b0};

        reset_n = 1'b1; btn_clr = 0; btn_load = 0; btn_run = 0; sw = '0; max_tick = 0;
        #2 reset_n = 1'b0;
        chk_on = 1'b1;
        step(5);
        reset_n = 1'b1;

        // Table-driven scenarios.
        for (int r = 0; r < 11; r++) begin
            c0 = tot_clr; l0 = tot_ld;
            sw = tbl[r].sw_v;
            btn_clr = tbl[r].clr; btn_load = tbl[r].ld; btn_run = tbl[r].run;
            step(tbl[r].hold);
            btn_clr = 0; btn_load = 0; btn_run = 0;
            step(40);
            if (tbl[r].mt) begin
                max_tick = 1'b1;
                step(1);
                max_tick = 1'b0;
                step(3);
            end
            check($sformatf("row%0d_clr_pulses", r), tot_clr - c0, tbl[r].exp_clr);
            check($sformatf("row%0d_load_pulses", r), tot_ld - l0, tbl[r].exp_ld);
            check($sformatf("row%0d_d", r), a_d, tbl[r].exp_d);
            check($sformatf("row%0d_en_auto", r), a_en, tbl[r].exp_en_a);
            check($sformatf("row%0d_en_free", r), b_en, tbl[r].exp_en_b);
        end

        // Reset in the middle of a run-button acceptance window.
        btn_run = 1'b1;
        step(12);
        check("mid_window_en", a_en, 1'b0);
        reset_n = 1'b0;
        step(2);
        check("mid_reset_d", a_d, 16'h0000);
        reset_n = 1'b1;
        step(16);
        check("held_after_reset_en", a_en, 1'b0);
        waited = 0;
        while (!a_en && waited < 40) begin
            step(1);
            waited++;
        end
        check("new_window_en_auto", a_en, 1'b1);
        check("new_window_en_free", b_en, 1'b1);
        btn_run = 1'b0;
        step(40);

        // Randomised button activity: mixture of glitches and long holds.
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; lvl[i] = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                          : $urandom_range(12, 45);
                end
                rem[i]--;
            end
            btn_clr = lvl[0]; btn_load = lvl[1]; btn_run = lvl[2];
            if ($urandom_range(0, 9) == 0) sw = W'($urandom);
            max_tick = ($urandom_range(0, 15) == 0);
            reset_n  = !(c >= 2000 && c < 2003);
            step(1);
        end
        btn_clr = 0; btn_load = 0; btn_run = 0; max_tick = 0; reset_n = 1'b1;
        step(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
